// File: rtl/pitch_tracker_if.sv
// Sample stream in, pitch measurement out.
//   sample_valid, sample : waveform samples from the producer
//   period, period_valid : last measured period and its one-cycle update strobe
//   locked               : a measurement is held and no timeout has occurred
//   edge_pulse           : one-cycle strobe on every detected rising crossing
// The master modport is the producer/consumer side; the tracker uses slave.
interface pitch_tracker_if #(
    parameter int BITDEPTH = 12,
    parameter int PERIOD_W = 16
);
    logic                sample_valid;
    logic [BITDEPTH-1:0] sample;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                locked;
    logic                edge_pulse;

    modport master (
        output sample_valid,
        output sample,
        input  period,
        input  period_valid,
        input  locked,
        input  edge_pulse
    );

    modport slave (
        input  sample_valid,
        input  sample,
        output period,
        output period_valid,
        output locked,
        output edge_pulse
    );
endinterface

// File: rtl/pitch_tracker.sv
// Pitch tracker: measures the period, in valid samples, of an offset-binary
// waveform by timing rising mid-scale crossings with hysteresis.
//   sample_clock : single clock, all state on its rising edge
//   rst_n        : asynchronous active-low reset
//   bus (slave)  : sample_valid/sample in; period, period_valid, locked,
//                  edge_pulse out (all outputs registered)
module pitch_tracker #(
    parameter int BITDEPTH = 12,
    parameter int HYST     = 256,
    parameter int PERIOD_W = 16
) (
    input  logic            sample_clock,
    input  logic            rst_n,
    pitch_tracker_if.slave  bus
);
    // Thresholds carry one extra bit so MID+HYST can never wrap.
    localparam int MID_I = 2 ** (BITDEPTH - 1);
    localparam logic [BITDEPTH:0] HI = (BITDEPTH + 1)'(MID_I + HYST);
    localparam logic [BITDEPTH:0] LO = (BITDEPTH + 1)'(MID_I - HYST);
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    state_t              state_reg, state_next;
    logic [PERIOD_W-1:0] cnt_reg, cnt_next;
    logic                have_edge_reg, have_edge_next;
    logic [PERIOD_W-1:0] period_reg, period_next;
    logic                period_valid_reg, period_valid_next;
    logic                locked_reg, locked_next;
    logic                edge_pulse_reg, edge_pulse_next;

    logic [BITDEPTH:0]   sample_ext;
    logic                rise_event;

    assign sample_ext = {1'b0, bus.sample};
    // A rising event is the single sample that reaches HI after LO was seen.
    assign rise_event = bus.sample_valid && (state_reg == WAIT_HIGH) && (sample_ext >= HI);

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        have_edge_next    = have_edge_reg;
        period_next       = period_reg;
        period_valid_next = 1'b0;
        locked_next       = locked_reg;
        edge_pulse_next   = 1'b0;

        if (bus.sample_valid) begin
            case (state_reg)
                WAIT_LOW:  if (sample_ext <= LO) state_next = WAIT_HIGH;
                WAIT_HIGH: if (sample_ext >= HI) state_next = WAIT_LOW;
                default:   state_next = WAIT_LOW;
            endcase

            if (rise_event) begin
                edge_pulse_next = 1'b1;
                cnt_next        = '0;
                have_edge_next  = 1'b1;
                // The first crossing after reset or timeout only arms the count.
                if (have_edge_reg) begin
                    period_next       = cnt_reg + PERIOD_W'(1);
                    period_valid_next = 1'b1;
                    locked_next       = 1'b1;
                end
            end else if (cnt_reg == CNT_MAX) begin
                // Counter saturated: the waveform is too slow or absent.
                have_edge_next = 1'b0;
                locked_next    = 1'b0;
            end else begin
                cnt_next = cnt_reg + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge sample_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= WAIT_LOW;
            cnt_reg          <= '0;
            have_edge_reg    <= 1'b0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            locked_reg       <= 1'b0;
            edge_pulse_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            have_edge_reg    <= have_edge_next;
            period_reg       <= period_next;
            period_valid_reg <= period_valid_next;
            locked_reg       <= locked_next;
            edge_pulse_reg   <= edge_pulse_next;
        end
    end

    assign bus.period       = period_reg;
    assign bus.period_valid = period_valid_reg;
    assign bus.locked       = locked_reg;
    assign bus.edge_pulse   = edge_pulse_reg;
endmodule

// File: tb/tb_pitch_tracker.sv
// Self-checking bench for pitch_tracker. Two instances share one stimulus:
// dut_a uses the default 16-bit period counter, dut_b an 8-bit counter so the
// timeout path is reachable. A per-cycle reference model of the crossing
// rules is compared against both, plus hand-computed spot checks.
module tb_pitch_tracker;
    localparam int BITDEPTH = 12;
    localparam int HYST     = 256;
    localparam int HI       = 2048 + HYST;
    localparam int LO       = 2048 - HYST;

    logic sample_clock = 1'b0;
    logic rst_n        = 1'b0;

    always #5 sample_clock = ~sample_clock;

    pitch_tracker_if #(.BITDEPTH(BITDEPTH), .PERIOD_W(16)) if_a ();
    pitch_tracker_if #(.BITDEPTH(BITDEPTH), .PERIOD_W(8))  if_b ();

    pitch_tracker #(.BITDEPTH(BITDEPTH), .HYST(HYST), .PERIOD_W(16)) dut_a (
        .sample_clock (sample_clock),
        .rst_n        (rst_n),
        .bus          (if_a)
    );

    pitch_tracker #(.BITDEPTH(BITDEPTH), .HYST(HYST), .PERIOD_W(8)) dut_b (
        .sample_clock (sample_clock),
        .rst_n        (rst_n),
        .bus          (if_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: whether a low excursion has been seen since the last
    // crossing, samples since last crossing, whether a crossing is on record.
    int cnt_max [2] = '{65535, 255};
    bit m_seen_low [2];
    int m_since    [2];
    bit m_have     [2];
    int m_period   [2];
    bit m_pv       [2];
    bit m_locked   [2];
    bit m_ep       [2];

    always @(posedge sample_clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_seen_low[k] <= 1'b0;
                m_since[k]    <= 0;
                m_have[k]     <= 1'b0;
                m_period[k]   <= 0;
                m_pv[k]       <= 1'b0;
                m_locked[k]   <= 1'b0;
                m_ep[k]       <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_pv[k] <= 1'b0;
                m_ep[k] <= 1'b0;
                if (if_a.sample_valid) begin
                    if (m_seen_low[k] && int'(if_a.sample) >= HI) begin
                        m_seen_low[k] <= 1'b0;
                        m_ep[k]       <= 1'b1;
                        m_since[k]    <= 0;
                        m_have[k]     <= 1'b1;
                        if (m_have[k]) begin
                            m_period[k] <= (m_since[k] + 1) % (cnt_max[k] + 1);
                            m_pv[k]     <= 1'b1;
                            m_locked[k] <= 1'b1;
                        end
                    end else begin
                        if (int'(if_a.sample) <= LO) m_seen_low[k] <= 1'b1;
                        if (m_since[k] == cnt_max[k]) begin
                            m_have[k]   <= 1'b0;
                            m_locked[k] <= 1'b0;
                        end else begin
                            m_since[k] <= m_since[k] + 1;
                        end
                    end
                end
            end
        end
    end

    // Outputs are compared mid-cycle, away from the active edge.
    always @(negedge sample_clock) begin
        check("a.period",       int'(if_a.period),       m_period[0]);
        check("a.period_valid", int'(if_a.period_valid), int'(m_pv[0]));
        check("a.locked",       int'(if_a.locked),       int'(m_locked[0]));
        check("a.edge_pulse",   int'(if_a.edge_pulse),   int'(m_ep[0]));
        check("b.period",       int'(if_b.period),       m_period[1]);
        check("b.period_valid", int'(if_b.period_valid), int'(m_pv[1]));
        check("b.locked",       int'(if_b.locked),       int'(m_locked[1]));
        check("b.edge_pulse",   int'(if_b.edge_pulse),   int'(m_ep[1]));
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input int s);
        if_a.sample_valid = v;
        if_b.sample_valid = v;
        if_a.sample       = BITDEPTH'(s);
        if_b.sample       = BITDEPTH'(s);
        @(posedge sample_clock);
        #1;
    endtask

    task automatic square_run(input int n_cycles, input int first_half);
        // first_half selects the starting level: 0 = high (2400), 1 = low (1700)
        for (int i = 0; i < n_cycles; i++)
            step(1'b1, (((i / 10) + first_half) % 2) != 0 ? 1700 : 2400);
    endtask

    int edges_seen;

    initial begin
        if_a.sample_valid = 1'b0;
        if_b.sample_valid = 1'b0;
        if_a.sample       = '0;
        if_b.sample       = '0;

        // Reset held with random activity on the inputs
        for (int i = 0; i < 6; i++) step(1'($urandom_range(1)), int'($urandom_range(4095)));
        check("reset.locked", int'(if_a.locked), 0);
        check("reset.period", int'(if_a.period), 0);
        check("reset.edge_pulse", int'(if_a.edge_pulse), 0);
        rst_n = 1'b1;

        // Saw with a 64-sample period
        for (int n = 0; n <= 300; n++) begin
            step(1'b1, (n * 64) % 4096);
            if (n == 36) begin
                check("saw.first_edge", int'(if_a.edge_pulse), 1);
                check("saw.first_no_report", int'(if_a.period_valid), 0);
            end
            if (n == 100) begin
                check("saw.second_pv", int'(if_a.period_valid), 1);
                check("saw.second_period", int'(if_a.period), 64);
                check("saw.second_locked", int'(if_a.locked), 1);
            end
        end

        // Valid gating: garbage on invalid cycles must be ignored
        for (int n = 0; n <= 300; n++) begin
            step(1'b1, (n * 64) % 4096);
            step(1'b0, (n % 2) != 0 ? 4095 : 0);
        end
        check("gate.period_a", int'(if_a.period), 64);
        check("gate.period_b", int'(if_b.period), 64);

        // Hysteresis: levels inside the dead band never cross
        edges_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (i % 2) != 0 ? 1900 : 2100);
            edges_seen += int'(if_a.edge_pulse) + int'(if_b.edge_pulse);
        end
        check("hyst.no_edges", edges_seen, 0);

        // Square outside the dead band, 10-sample half period
        square_run(100, 0);
        check("square.period_a", int'(if_a.period), 20);
        check("square.period_b", int'(if_b.period), 20);
        check("square.locked_b", int'(if_b.locked), 1);

        // Timeout on the 8-bit instance
        for (int i = 0; i < 300; i++) step(1'b1, 1000);
        check("timeout.locked_b", int'(if_b.locked), 0);
        check("timeout.period_b", int'(if_b.period), 20);
        check("timeout.locked_a", int'(if_a.locked), 1);

        step(1'b1, 2400);
        check("rearm.edge_b", int'(if_b.edge_pulse), 1);
        check("rearm.no_report_b", int'(if_b.period_valid), 0);
        check("rearm.still_unlocked_b", int'(if_b.locked), 0);
        for (int i = 0; i < 9; i++)  step(1'b1, 2400);
        for (int i = 0; i < 10; i++) step(1'b1, 1700);
        step(1'b1, 2400);
        check("relock.pv_b", int'(if_b.period_valid), 1);
        check("relock.period_b", int'(if_b.period), 20);
        check("relock.locked_b", int'(if_b.locked), 1);

        // Reset mid-measurement
        for (int i = 0; i < 5; i++) step(1'b1, 2400);
        rst_n = 1'b0;
        #1;
        check("midreset.locked_a", int'(if_a.locked), 0);
        check("midreset.period_a", int'(if_a.period), 0);
        check("midreset.locked_b", int'(if_b.locked), 0);
        @(posedge sample_clock);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 1700);
        step(1'b1, 2400);
        check("fresh.edge_a", int'(if_a.edge_pulse), 1);
        check("fresh.no_report_a", int'(if_a.period_valid), 0);
        for (int i = 0; i < 9; i++)  step(1'b1, 2400);
        for (int i = 0; i < 10; i++) step(1'b1, 1700);
        step(1'b1, 2400);
        check("fresh.pv_a", int'(if_a.period_valid), 1);
        check("fresh.period_a", int'(if_a.period), 20);
        check("fresh.locked_a", int'(if_a.locked), 1);

        square_run(60, 1);
        step(1'b0, 0);
        step(1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
